// File: rtl/icache_line_fill.sv
`default_nettype none
// ============================================================================
//  Module   : icache_line_fill
//  Purpose  : Memory-side line-fill engine for the instruction cache. On a
//             miss it issues one 64-byte read on the system bus, collects
//             LINE_BEATS response beats into a full line and reports a
//             bit-granular progress count that reaches 512 when the line is
//             complete.
//  Options  : ICACHE_FILL_RESPTAG_CHECK_EN - when defined, response beats are
//             accepted only if bus_resptag matches REQ_TAG.
//  Revision : 1.0 - initial release
// ============================================================================
module icache_line_fill #(
  parameter int                         BUS_DATA_WIDTH = 64,
  parameter int                         BUS_TAG_WIDTH  = 13,
  parameter logic [BUS_TAG_WIDTH-1:0]   REQ_TAG        = 13'h1100,
  parameter int                         LINE_BEATS     = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,        // async, active-low
  // icache side
  input  logic                                 in_miss,
  input  logic [BUS_DATA_WIDTH-1:0]            in_pc,
  input  logic                                 in_stall,
  // bus request channel
  output logic                                 bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]            bus_req,
  output logic [BUS_TAG_WIDTH-1:0]             bus_reqtag,
  input  logic                                 bus_reqack,
  // bus response channel
  input  logic                                 bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]            bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]             bus_resptag,
  output logic                                 bus_respack,
  // fill result towards the icache
  output logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] out_data,
  output logic [9:0]                           out_offset,
  output logic                                 out_busy
);

  localparam int                   LINE_W      = BUS_DATA_WIDTH * LINE_BEATS;
  localparam int                   LINE_ALIGN  = $clog2(LINE_W / 8);
  localparam int                   BEAT_W      = $clog2(LINE_BEATS);
  localparam int                   OFFSET_W    = 10;
  localparam logic [OFFSET_W-1:0]  OFFSET_STEP = OFFSET_W'(BUS_DATA_WIDTH);
  localparam logic [BEAT_W-1:0]    LAST_BEAT   = BEAT_W'(LINE_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                   state_q;
  logic [BEAT_W-1:0]        beat_q;
  logic [BEAT_W-1:0]        beat_d;
  logic [LINE_W-1:0]        data_q;
  logic [OFFSET_W-1:0]      offset_q;
  logic [OFFSET_W-1:0]      offset_d;
  logic                     reqcyc_q;
  logic [BUS_DATA_WIDTH-1:0] req_q;
  logic [BUS_TAG_WIDTH-1:0] reqtag_q;
  logic                     tag_ok;
  logic                     accept;

  // Beat qualification: optionally filter responses that belong to another requester.
`ifdef ICACHE_FILL_RESPTAG_CHECK_EN
  assign tag_ok = (bus_resptag == REQ_TAG);
`else
  assign tag_ok = 1'b1;
`endif

  // A beat is only taken while collecting; a response arriving together with
  // the request ack is left on the bus for the responder to re-present.
  assign accept   = (state_q == RESP) && bus_respcyc && tag_ok;

  // Progress counters advance together; the beat index wraps to 0 after the
  // last beat, the DONE state acting as the line-complete flag.
  assign beat_d   = beat_q + 1'b1;
  assign offset_d = offset_q + OFFSET_STEP;

  // Fill sequencer: latch the miss, hold the request, collect beats, hand off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      data_q   <= '0;
      offset_q <= '0;
      reqcyc_q <= 1'b0;
      req_q    <= '0;
      reqtag_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          offset_q <= '0;
          if (in_miss) begin
            beat_q   <= '0;
            reqcyc_q <= 1'b1;
            req_q    <= {in_pc[BUS_DATA_WIDTH-1:LINE_ALIGN], {LINE_ALIGN{1'b0}}};
            reqtag_q <= REQ_TAG;
            state_q  <= REQ;
          end
        end
        REQ: begin
          if (bus_reqack) begin
            reqcyc_q <= 1'b0;
            req_q    <= '0;
            reqtag_q <= '0;
            state_q  <= RESP;
          end
        end
        RESP: begin
          if (accept) begin
            data_q[beat_q*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= bus_resp;
            beat_q   <= beat_d;
            offset_q <= offset_d;
            if (beat_q == LAST_BEAT) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          // The icache samples the line on the first unstalled cycle.
          if (!in_stall) begin
            offset_q <= '0;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_reqcyc  = reqcyc_q;
  assign bus_req     = req_q;
  assign bus_reqtag  = reqtag_q;
  assign bus_respack = accept;
  assign out_data    = data_q;
  assign out_offset  = offset_q;
  assign out_busy    = (state_q != IDLE);

  // Line-offset address bits and (in the default build) the response tag
  // carry no information for this block.
  logic unused_inputs;
  assign unused_inputs = ^{in_pc[LINE_ALIGN-1:0], bus_resptag};

endmodule
`default_nettype wire

// File: tb/tb_icache_line_fill.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_line_fill
//  Purpose  : Self-checking bench for icache_line_fill. A line model keeps
//             the last value written to each beat slot; expected progress is
//             derived from the count of beats the bus rules say are accepted.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icache_line_fill;

  localparam logic [12:0] REQ_TAG = 13'h1100;

  logic         clk         = 1'b0;
  logic         reset       = 1'b1;
  logic         in_miss     = 1'b0;
  logic [63:0]  in_pc       = '0;
  logic         in_stall    = 1'b0;
  logic         bus_reqcyc;
  logic [63:0]  bus_req;
  logic [12:0]  bus_reqtag;
  logic         bus_reqack  = 1'b0;
  logic         bus_respcyc = 1'b0;
  logic [63:0]  bus_resp    = '0;
  logic [12:0]  bus_resptag = REQ_TAG;
  logic         bus_respack;
  logic [511:0] out_data;
  logic [9:0]   out_offset;
  logic         out_busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: last data written into each 64-bit slot of the line.
  logic [63:0] mdl_beat [8];

  always #5 clk = ~clk;

  icache_line_fill dut (
    .clk         (clk),
    .reset       (reset),
    .in_miss     (in_miss),
    .in_pc       (in_pc),
    .in_stall    (in_stall),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .bus_respack (bus_respack),
    .out_data    (out_data),
    .out_offset  (out_offset),
    .out_busy    (out_busy)
  );

  function automatic logic [511:0] mdl_line();
    logic [511:0] line;
    for (int k = 0; k < 8; k++) line[64*k +: 64] = mdl_beat[k];
    return line;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 8; k++) mdl_beat[k] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_miss(input logic [63:0] pc);
    in_pc   = pc;
    in_miss = 1'b1;
    tick();
    in_miss = 1'b0;
    in_pc   = {$urandom, $urandom};
  endtask

  task automatic grant(input int dly);
    repeat (dly) tick();
    bus_reqack = 1'b1;
    tick();
    bus_reqack = 1'b0;
  endtask

  // Presents one beat for a single cycle; returns the same-cycle ack.
  task automatic send_beat(input logic [63:0] d, input logic [12:0] tag, output logic ack);
    bus_respcyc = 1'b1;
    bus_resp    = d;
    bus_resptag = tag;
    #1;
    ack = bus_respack;
    tick();
    bus_respcyc = 1'b0;
    bus_resp    = {$urandom, $urandom};
    bus_resptag = REQ_TAG;
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    n_checks++; if (out_offset !== 10'd0) $display("FAIL reset_offset: got %0d expected 0", out_offset); else n_pass++;
    n_checks++; if (out_data !== 512'd0) $display("FAIL reset_data: got %h expected 0", out_data); else n_pass++;
    n_checks++; if ({bus_reqcyc, bus_req, bus_reqtag} !== 78'd0) $display("FAIL reset_req: got cyc=%b req=%h tag=%h expected all 0", bus_reqcyc, bus_req, bus_reqtag); else n_pass++;
    n_checks++; if (out_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", out_busy); else n_pass++;
    bus_respcyc = 1'b1;
    in_miss     = 1'b1;
    tick();
    tick();
    n_checks++; if ({out_busy, bus_respack, bus_reqcyc} !== 3'b000) $display("FAIL reset_held: got busy/ack/reqcyc=%b expected 000", {out_busy, bus_respack, bus_reqcyc}); else n_pass++;
    bus_respcyc = 1'b0;
    in_miss     = 1'b0;
    reset       = 1'b1;
    tick();
    n_checks++; if (out_busy !== 1'b0) $display("FAIL reset_release_busy: got %b expected 0", out_busy); else n_pass++;
    clear_model();
  endtask

  task automatic test_basic_fill();
    logic [63:0] pc, d;
    logic        ack;
    int          dly;
    for (int f = 0; f < 4; f++) begin
      pc  = (f == 0) ? 64'h0000_1234 : {$urandom, $urandom};
      dly = (f == 0) ? 2 : int'($urandom_range(0, 3));
      issue_miss(pc);
      n_checks++; if (bus_reqcyc !== 1'b1) $display("FAIL basic_reqcyc: got %b expected 1", bus_reqcyc); else n_pass++;
      n_checks++; if (bus_req !== {pc[63:6], 6'b0}) $display("FAIL basic_req_addr: got %h expected %h", bus_req, {pc[63:6], 6'b0}); else n_pass++;
      n_checks++; if (bus_reqtag !== REQ_TAG) $display("FAIL basic_reqtag: got %h expected %h", bus_reqtag, REQ_TAG); else n_pass++;
      n_checks++; if (out_busy !== 1'b1) $display("FAIL basic_busy: got %b expected 1", out_busy); else n_pass++;
      for (int w = 0; w < dly; w++) begin
        tick();
        n_checks++; if ({bus_reqcyc, bus_req} !== {1'b1, pc[63:6], 6'b0}) $display("FAIL basic_req_hold: got cyc=%b req=%h expected 1 %h", bus_reqcyc, bus_req, {pc[63:6], 6'b0}); else n_pass++;
      end
      grant(0);
      n_checks++; if ({bus_reqcyc, bus_req, bus_reqtag} !== 78'd0) $display("FAIL basic_req_drop: got cyc=%b req=%h tag=%h expected all 0", bus_reqcyc, bus_req, bus_reqtag); else n_pass++;
      for (int b = 0; b < 8; b++) begin
        d = (f == 0) ? 64'(b) : {$urandom, $urandom};
        send_beat(d, REQ_TAG, ack);
        mdl_beat[b] = d;
        n_checks++; if (ack !== 1'b1) $display("FAIL basic_respack: beat %0d got %b expected 1", b, ack); else n_pass++;
        n_checks++; if (out_offset !== 10'(64*(b+1))) $display("FAIL basic_offset: beat %0d got %0d expected %0d", b, out_offset, 64*(b+1)); else n_pass++;
      end
      n_checks++; if (out_data !== mdl_line()) $display("FAIL basic_line: got %h expected %h", out_data, mdl_line()); else n_pass++;
      tick();
      n_checks++; if ({out_busy, out_offset} !== 11'd0) $display("FAIL basic_idle: got busy=%b offset=%0d expected 0 0", out_busy, out_offset); else n_pass++;
      n_checks++; if (out_data !== mdl_line()) $display("FAIL basic_retain: got %h expected %h", out_data, mdl_line()); else n_pass++;
    end
  endtask

  task automatic test_bubbles();
    logic [63:0] pc, d;
    logic        ack;
    pc = {$urandom, $urandom};
    issue_miss(pc);
    grant(1);
    for (int b = 0; b < 8; b++) begin
      if (b == 4) begin
        for (int g = 0; g < 3; g++) begin
          bus_respcyc = 1'b0;
          bus_resp    = {$urandom, $urandom};
          #1;
          n_checks++; if (bus_respack !== 1'b0) $display("FAIL bubble_ack: got %b expected 0", bus_respack); else n_pass++;
          tick();
          n_checks++; if (out_offset !== 10'd256) $display("FAIL bubble_offset: got %0d expected 256", out_offset); else n_pass++;
          n_checks++; if (out_data !== mdl_line()) $display("FAIL bubble_data: got %h expected %h", out_data, mdl_line()); else n_pass++;
        end
      end
      d = {$urandom, $urandom};
      send_beat(d, REQ_TAG, ack);
      mdl_beat[b] = d;
      n_checks++; if (ack !== 1'b1) $display("FAIL bubble_respack: beat %0d got %b expected 1", b, ack); else n_pass++;
    end
    n_checks++; if (out_offset !== 10'd512) $display("FAIL bubble_final_offset: got %0d expected 512", out_offset); else n_pass++;
    n_checks++; if (out_data !== mdl_line()) $display("FAIL bubble_line: got %h expected %h", out_data, mdl_line()); else n_pass++;
    tick();
  endtask

  task automatic test_stall_done();
    logic [63:0] d;
    logic        ack;
    issue_miss({$urandom, $urandom});
    grant(0);
    for (int b = 0; b < 8; b++) begin
      if (b == 7) in_stall = 1'b1;
      d = {$urandom, $urandom};
      send_beat(d, REQ_TAG, ack);
      mdl_beat[b] = d;
    end
    for (int s = 0; s < 5; s++) begin
      bus_respcyc = 1'b1;
      bus_resp    = {$urandom, $urandom};
      #1;
      n_checks++; if (bus_respack !== 1'b0) $display("FAIL stall_stray_ack: got %b expected 0", bus_respack); else n_pass++;
      tick();
      n_checks++; if ({out_busy, out_offset} !== {1'b1, 10'd512}) $display("FAIL stall_hold: cycle %0d got busy=%b offset=%0d expected 1 512", s, out_busy, out_offset); else n_pass++;
      n_checks++; if (out_data !== mdl_line()) $display("FAIL stall_data: got %h expected %h", out_data, mdl_line()); else n_pass++;
    end
    bus_respcyc = 1'b0;
    in_stall    = 1'b0;
    tick();
    n_checks++; if ({out_busy, out_offset} !== 11'd0) $display("FAIL stall_release: got busy=%b offset=%0d expected 0 0", out_busy, out_offset); else n_pass++;
  endtask

  task automatic test_reset_mid_fill();
    logic [63:0] pc, d;
    logic        ack;
    issue_miss({$urandom, $urandom});
    grant(0);
    for (int b = 0; b < 4; b++) begin
      d = {$urandom, $urandom};
      send_beat(d, REQ_TAG, ack);
      mdl_beat[b] = d;
    end
    n_checks++; if (out_offset !== 10'd256) $display("FAIL midrst_pre_offset: got %0d expected 256", out_offset); else n_pass++;
    #1 reset = 1'b0;
    #1;
    clear_model();
    n_checks++; if ({out_busy, out_offset, bus_reqcyc} !== 12'd0) $display("FAIL midrst_async: got busy=%b offset=%0d reqcyc=%b expected 0", out_busy, out_offset, bus_reqcyc); else n_pass++;
    n_checks++; if (out_data !== 512'd0) $display("FAIL midrst_data: got %h expected 0", out_data); else n_pass++;
    bus_respcyc = 1'b1;
    bus_resp    = {$urandom, $urandom};
    tick();
    reset = 1'b1;
    #1;
    n_checks++; if (bus_respack !== 1'b0) $display("FAIL midrst_late_ack: got %b expected 0", bus_respack); else n_pass++;
    tick();
    bus_respcyc = 1'b0;
    n_checks++; if ({out_offset, out_data} !== 522'd0) $display("FAIL midrst_late_beat: got offset=%0d data=%h expected 0", out_offset, out_data); else n_pass++;
    pc = {$urandom, $urandom};
    issue_miss(pc);
    n_checks++; if ({bus_reqcyc, bus_req} !== {1'b1, pc[63:6], 6'b0}) $display("FAIL midrst_new_req: got cyc=%b req=%h expected 1 %h", bus_reqcyc, bus_req, {pc[63:6], 6'b0}); else n_pass++;
    grant(2);
    for (int b = 0; b < 8; b++) begin
      d = {$urandom, $urandom};
      send_beat(d, REQ_TAG, ack);
      mdl_beat[b] = d;
    end
    n_checks++; if ({out_offset, out_data} !== {10'd512, mdl_line()}) $display("FAIL midrst_refill: got offset=%0d data=%h expected 512 %h", out_offset, out_data, mdl_line()); else n_pass++;
    tick();
  endtask

  task automatic test_ignored_inputs();
    logic [63:0] pc, d;
    logic        ack;
    bus_respcyc = 1'b1;
    bus_resp    = {$urandom, $urandom};
    #1;
    n_checks++; if (bus_respack !== 1'b0) $display("FAIL ign_idle_ack: got %b expected 0", bus_respack); else n_pass++;
    tick();
    bus_respcyc = 1'b0;
    n_checks++; if ({out_busy, out_offset, out_data} !== {11'd0, mdl_line()}) $display("FAIL ign_idle_state: got busy=%b offset=%0d data=%h", out_busy, out_offset, out_data); else n_pass++;
    pc = {$urandom, $urandom};
    issue_miss(pc);
    for (int i = 0; i < 4; i++) begin
      in_miss     = 1'b1;
      in_pc       = {$urandom, $urandom};
      bus_respcyc = 1'b1;
      bus_resp    = {$urandom, $urandom};
      #1;
      n_checks++; if (bus_respack !== 1'b0) $display("FAIL ign_req_ack: got %b expected 0", bus_respack); else n_pass++;
      tick();
      n_checks++; if ({bus_reqcyc, bus_req} !== {1'b1, pc[63:6], 6'b0}) $display("FAIL ign_req_addr: got cyc=%b req=%h expected 1 %h", bus_reqcyc, bus_req, {pc[63:6], 6'b0}); else n_pass++;
      n_checks++; if (out_offset !== 10'd0) $display("FAIL ign_req_offset: got %0d expected 0", out_offset); else n_pass++;
    end
    in_miss    = 1'b0;
    bus_reqack = 1'b1;
    bus_resp   = {$urandom, $urandom};
    #1;
    n_checks++; if (bus_respack !== 1'b0) $display("FAIL ign_ack_with_resp: got %b expected 0", bus_respack); else n_pass++;
    tick();
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    n_checks++; if ({bus_reqcyc, out_offset, out_data} !== {11'd0, mdl_line()}) $display("FAIL ign_beat_dropped: got cyc=%b offset=%0d data=%h", bus_reqcyc, out_offset, out_data); else n_pass++;
    in_miss = 1'b1;
    for (int b = 0; b < 8; b++) begin
      d = {$urandom, $urandom};
      send_beat(d, REQ_TAG, ack);
      mdl_beat[b] = d;
      n_checks++; if (ack !== 1'b1) $display("FAIL ign_resp_ack: beat %0d got %b expected 1", b, ack); else n_pass++;
    end
    in_miss = 1'b0;
    n_checks++; if ({bus_reqcyc, out_offset, out_data} !== {1'b0, 10'd512, mdl_line()}) $display("FAIL ign_line: got cyc=%b offset=%0d data=%h", bus_reqcyc, out_offset, out_data); else n_pass++;
    tick();
    tick();
    n_checks++; if ({out_busy, bus_reqcyc, out_offset} !== 12'd0) $display("FAIL ign_no_second_req: got busy=%b reqcyc=%b offset=%0d expected 0", out_busy, bus_reqcyc, out_offset); else n_pass++;
  endtask

  task automatic test_resptag();
    logic [63:0] d;
    logic        ack;
    issue_miss({$urandom, $urandom});
    grant(1);
    for (int b = 0; b < 8; b++) begin
      if (b == 2 || b == 5) begin
        d = {$urandom, $urandom};
        send_beat(d, 13'h0001, ack);
`ifdef ICACHE_FILL_RESPTAG_CHECK_EN
        n_checks++; if (ack !== 1'b0) $display("FAIL tag_mismatch_ack: got %b expected 0", ack); else n_pass++;
        n_checks++; if (out_offset !== 10'(64*b)) $display("FAIL tag_mismatch_offset: got %0d expected %0d", out_offset, 64*b); else n_pass++;
`else
        mdl_beat[b] = d;
        n_checks++; if (ack !== 1'b1) $display("FAIL tag_ignored_ack: got %b expected 1", ack); else n_pass++;
        n_checks++; if (out_offset !== 10'(64*(b+1))) $display("FAIL tag_ignored_offset: got %0d expected %0d", out_offset, 64*(b+1)); else n_pass++;
        continue;
`endif
      end
      d = {$urandom, $urandom};
      send_beat(d, REQ_TAG, ack);
      mdl_beat[b] = d;
      n_checks++; if (ack !== 1'b1) $display("FAIL tag_match_ack: beat %0d got %b expected 1", b, ack); else n_pass++;
    end
    n_checks++; if ({out_offset, out_data} !== {10'd512, mdl_line()}) $display("FAIL tag_line: got offset=%0d data=%h expected 512 %h", out_offset, out_data, mdl_line()); else n_pass++;
    tick();
  endtask

  initial begin
    clear_model();
    test_reset();
    test_basic_fill();
    test_bubbles();
    test_stall_done();
    test_reset_mid_fill();
    test_ignored_inputs();
    test_resptag();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
